simple_register: RTL and testbench
==================================

SIMPLE_REGISTER -- requirements
Module: simple_register

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits for inputData and outputData.
REQ-002 Parameter: RESET_VALUE, default {WIDTH{1'b0}}, value loaded into the register by reset.
REQ-003 Port: clock  input  1  single system clock; all state changes on rising edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-005 Port: inputData  input  WIDTH  data to be captured.
REQ-006 Port: outputData  output  WIDTH  registered copy of inputData, driven directly from a flop bank.
REQ-007 Clocking/reset: one clock, reset is synchronous and active-high.

Function
REQ-008 The module SHALL hold a WIDTH-bit register whose value drives outputData continuously, with no combinational path from inputData to outputData.
REQ-009 The register SHALL load inputData on every rising edge of clock when reset is 0; there is no enable, so the register loads every cycle.
REQ-010 Latency SHALL be exactly one clock: the value present on inputData at rising edge N SHALL appear on outputData immediately after edge N and hold until edge N+1.
REQ-011 Changes on inputData between rising edges SHALL NOT affect outputData.
REQ-012 All WIDTH bits SHALL be captured in parallel with no bit reordering, truncation or extension.
REQ-013 Behaviour SHALL be identical for every data pattern, including all-zeros, all-ones and alternating patterns.
REQ-014 outputData SHALL NOT glitch between edges; it changes only as a direct result of a rising clock edge.

Reset
REQ-015 When reset is 1 at a rising edge, the register SHALL load RESET_VALUE, and outputData SHALL equal RESET_VALUE after that edge.
REQ-016 Reset SHALL take priority over data capture when both apply at the same edge, and inputData SHALL be ignored at that edge.
REQ-017 Assertion or deassertion of reset between edges SHALL have no effect until the next rising edge (no asynchronous path).
REQ-018 On the first rising edge with reset at 0 after reset deasserts, the register SHALL resume capturing inputData.
REQ-019 Before the first rising edge, the register value is unspecified; users SHALL NOT rely on it, and a reset or any clock edge defines it.
REQ-020 Holding reset at 1 for multiple cycles SHALL keep outputData at RESET_VALUE for every one of those cycles.

Verification (100 ns clock period, first rising edge at 50 ns; inputData changes on falling edges)
REQ-021 Basic capture: reset=0; inputData 0x00 at 0 ns, then 0xAF at 100 ns, 0xAC at 200 ns, 0xF0 at 300 ns, 0xFF at 400 ns -> outputData is 0x00 after 50 ns, 0xAF after 150 ns, 0xAC after 250 ns, 0xF0 after 350 ns, 0xFF after 450 ns.
REQ-022 Mid-cycle change: inputData 0x12 before an edge, then changed to 0x34 at the middle of the following high phase -> outputData stays 0x12 until the next rising edge, then becomes 0x34.
REQ-023 Reset priority: outputData=0xFF, inputData=0x5A, reset=1 at one edge -> outputData=0x00 after that edge; reset=0 at the next edge -> outputData=0x5A.
REQ-024 Synchronous reset check: reset pulsed high only during the low phase of the clock and cleared before the rising edge -> outputData unchanged; a reset pulse spanning a rising edge -> outputData=RESET_VALUE.
REQ-025 Parameter override: WIDTH=16, RESET_VALUE=0xA5A5; reset at one edge -> outputData=0xA5A5; then inputData=0xFFFF -> outputData=0xFFFF one edge later.

Source files
------------

// File: rtl/simple_register_if.sv
// Data bus for simple_register: the value to capture and the registered copy.
// The master drives inputData; the register (slave) drives outputData.
interface simple_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] inputData;
    logic [WIDTH-1:0] outputData;

    modport master (
        output inputData,
        input  outputData
    );

    modport slave (
        input  inputData,
        output outputData
    );
endinterface

// File: rtl/simple_register.sv
// WIDTH-bit register that loads its input on every rising clock edge.
// A synchronous reset loads RESET_VALUE and overrides the capture.
module simple_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic           clock,
    input  logic           reset,
    simple_register_if.slave bus
);
    logic [WIDTH-1:0] stored;

    // No enable: the flop bank loads every cycle, and reset wins when both apply.
    always_ff @(posedge clock) begin
        if (reset) begin
            stored <= RESET_VALUE;
        end else begin
            stored <= bus.inputData;
        end
    end

    // The output comes straight from the flops, so it can only move on an edge.
    assign bus.outputData = stored;
endmodule

// File: tb/tb_simple_register.sv
// Scoreboard bench: stimulus pushes expected values, a monitor checks them after each edge.
// Covers an 8-bit default instance and a 16-bit instance with a non-zero reset value.
module tb_simple_register;
    typedef struct {
        logic [15:0] value;
        string       name;
    } expect_t;

    logic clock;
    logic reset;
    logic reset16;

    simple_register_if #(.WIDTH(8))  bus8  ();
    simple_register_if #(.WIDTH(16)) bus16 ();

    simple_register dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    simple_register #(
        .WIDTH       (16),
        .RESET_VALUE (16'hA5A5)
    ) dut16 (
        .clock (clock),
        .reset (reset16),
        .bus   (bus16.slave)
    );

    expect_t q8[$];
    expect_t q16[$];
    int testsRun  = 0;
    int testsFail = 0;

    // 100 ns period, first rising edge at 50 ns, falling edges on multiples of 100 ns.
    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    task automatic compare(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [7:0] data, input logic [7:0] expected, input string name);
        expect_t e;
        reset          = rst;
        bus8.inputData = data;
        e.value        = {8'h00, expected};
        e.name         = name;
        q8.push_back(e);
    endtask

    task automatic applyStimulus16(input logic rst, input logic [15:0] data, input logic [15:0] expected, input string name);
        expect_t e;
        reset16         = rst;
        bus16.inputData = data;
        e.value         = expected;
        e.name          = name;
        q16.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        compare(name, {8'h00, bus8.outputData}, {8'h00, expected});
    endtask

    // Monitor: one step after each rising edge, pop whatever was expected for that edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                compare(e.name, {8'h00, bus8.outputData}, e.value);
            end
            if (q16.size() > 0) begin
                e = q16.pop_front();
                compare(e.name, bus16.outputData, e.value);
            end
        end
    end

    initial begin
        reset16         = 1'b0;
        bus16.inputData = 16'h0000;

        // Reset state, then basic capture of a pattern sequence.
        applyStimulus(1'b1, 8'h77, 8'h00, "reset_state");
        @(negedge clock); applyStimulus(1'b0, 8'h00, 8'h00, "capture_00");
        @(negedge clock); applyStimulus(1'b0, 8'hAF, 8'hAF, "capture_AF");
        @(negedge clock); applyStimulus(1'b0, 8'hAC, 8'hAC, "capture_AC");
        @(negedge clock); applyStimulus(1'b0, 8'hF0, 8'hF0, "capture_F0");
        @(negedge clock); applyStimulus(1'b0, 8'hFF, 8'hFF, "capture_FF");

        // Reset wins over capture, then capture resumes.
        @(negedge clock); applyStimulus(1'b1, 8'h5A, 8'h00, "reset_priority");
        @(negedge clock); applyStimulus(1'b0, 8'h5A, 8'h5A, "resume_5A");

        // Reset held across several edges.
        @(negedge clock); applyStimulus(1'b1, 8'h33, 8'h00, "reset_hold_1");
        @(negedge clock); applyStimulus(1'b1, 8'hCC, 8'h00, "reset_hold_2");
        @(negedge clock); applyStimulus(1'b1, 8'h55, 8'h00, "reset_hold_3");
        @(negedge clock); applyStimulus(1'b0, 8'h55, 8'h55, "release_55");
        @(negedge clock); applyStimulus(1'b0, 8'hAA, 8'hAA, "capture_AA");

        // A reset pulse confined to the low phase must not reach the register.
        @(negedge clock); applyStimulus(1'b0, 8'h3C, 8'h3C, "capture_3C");
        @(negedge clock); applyStimulus(1'b0, 8'h3C, 8'h3C, "low_phase_reset");
        #10 reset = 1'b1;
        #30 reset = 1'b0;

        // A reset pulse spanning a rising edge does reach it.
        @(negedge clock); applyStimulus(1'b1, 8'h99, 8'h00, "spanning_reset");
        @(posedge clock);
        #10 reset = 1'b0;
        @(negedge clock); applyStimulus(1'b0, 8'h0F, 8'h0F, "after_span_0F");

        // Input change in the middle of the high phase waits for the next edge.
        @(negedge clock); applyStimulus(1'b0, 8'h12, 8'h12, "mid_cycle_12");
        @(posedge clock);
        #25 applyStimulus(1'b0, 8'h34, 8'h34, "mid_cycle_34");
        #15 checkOutput("mid_cycle_hold", 8'h12);

        // Parameter override instance.
        @(negedge clock); applyStimulus16(1'b1, 16'h1234, 16'hA5A5, "w16_reset");
        @(negedge clock); applyStimulus16(1'b0, 16'hFFFF, 16'hFFFF, "w16_capture_FFFF");
        @(negedge clock); applyStimulus16(1'b0, 16'h5A5A, 16'h5A5A, "w16_capture_5A5A");

        @(negedge clock);
        @(negedge clock);
        testsRun++;
        if (q8.size() != 0 || q16.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q8.size(), q16.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end
endmodule
